// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared rv32 front-end types and defaults
package rv32_pkg;

  // Default first-fetch address and the bubble instruction (addi x0,x0,0)
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_VALID   = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_t;

  // Instruction formats shared by decode and immediate generation
  typedef enum logic [2:0] {
    INST_I  = 3'd0,
    INST_S  = 3'd1,
    INST_SB = 3'd2,
    INST_UJ = 3'd3,
    INST_U  = 3'd4
  } inst_type_t;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with sequential and redirect loads
module pc_register
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load_seq,
  input  logic        i_load_redirect,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc,
  output logic        o_misaligned
);

  logic [31:0] r_pc;
  logic        r_misaligned;

  // Redirect beats sequential advance; target is forced word-aligned, pc+4 wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= i_load_redirect && (i_target[1:0] != 2'b00);
      if (i_load_redirect) begin
        r_pc <= {i_target[31:2], 2'b00};
      end else if (i_load_seq) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  assign o_pc         = r_pc;
  assign o_misaligned = r_misaligned;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32 instruction fetch stage with redirect handling
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        misaligned_err
);

  localparam logic [1:0] S_IDLE    = FS_IDLE;
  localparam logic [1:0] S_FETCH   = FS_FETCH;
  localparam logic [1:0] S_VALID   = FS_VALID;
  localparam logic [1:0] S_DISCARD = FS_DISCARD;

  logic [1:0]  r_state;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic [31:0] r_req_addr;
  logic [31:0] w_pc;
  logic        w_load_seq;
  logic        w_misaligned;

  // Consuming a held instruction advances the pc; redirect priority lives in pc_register
  assign w_load_seq = (r_state == S_VALID) && !stall;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk            (clk),
    .rst            (rst),
    .i_load_seq     (w_load_seq),
    .i_load_redirect(redirect),
    .i_target       (redirect_target),
    .o_pc           (w_pc),
    .o_misaligned   (w_misaligned)
  );

  // Fetch sequencing: request, capture, hold for decode, or drain a stale request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_inst       <= NOP_INST;
      r_inst_pc    <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_req_addr   <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (redirect) begin
            // Without an ack the old request is still open and must be drained
            if (!imem_ack) begin
              r_state    <= S_DISCARD;
              r_req_addr <= w_pc;
            end
          end else if (imem_ack) begin
            r_inst       <= imem_rdata;
            r_inst_pc    <= w_pc;
            r_inst_valid <= 1'b1;
            r_state      <= S_VALID;
          end
        end
        S_VALID: begin
          if (redirect || !stall) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_ack && !redirect) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A draining request keeps its original address even after pc has moved on
  assign imem_req       = (r_state == S_FETCH) || (r_state == S_DISCARD);
  assign imem_addr      = (r_state == S_DISCARD) ? r_req_addr : w_pc;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_valid     = r_inst_valid;
  assign misaligned_err = w_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;

  logic        imem_req, imem_ack, stall, redirect, inst_valid, misaligned_err;
  logic [31:0] imem_addr, imem_rdata, redirect_target, inst, inst_pc;

  logic        b_req, b_ack, b_stall, b_redirect, b_valid, b_mis;
  logic [31:0] b_addr, b_rdata, b_target, b_inst, b_inst_pc;

  int total;
  int bad;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .misaligned_err (misaligned_err)
  );

  fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC)
  ) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (b_req),
    .imem_addr      (b_addr),
    .imem_ack       (b_ack),
    .imem_rdata     (b_rdata),
    .stall          (b_stall),
    .redirect       (b_redirect),
    .redirect_target(b_target),
    .inst           (b_inst),
    .inst_pc        (b_inst_pc),
    .inst_valid     (b_valid),
    .misaligned_err (b_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] tg;
    logic        st;
    logic        ak;
    logic [31:0] rdt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_mis;
  } vec_t;

  function automatic vec_t mk(logic rd, logic [31:0] tg, logic st, logic ak, logic [31:0] rdt,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ei,
                              logic [31:0] ep, logic em);
    vec_t v;
    v.rd = rd; v.tg = tg; v.st = st; v.ak = ak; v.rdt = rdt;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_ipc = ep; v.e_mis = em;
    return v;
  endfunction

  // Reference model: what the fetch stage is doing, described by intent
  logic        m_started;
  logic        m_held;
  logic        m_discard;
  logic [31:0] m_pc;
  logic [31:0] m_old;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic        m_mis;

  task automatic model_reset();
    m_started = 1'b0; m_held = 1'b0; m_discard = 1'b0;
    m_pc = 32'h0; m_old = 32'h0; m_inst = NOP; m_ipc = 32'h0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic rd, input logic [31:0] tg, input logic st,
                            input logic ak, input logic [31:0] rdt);
    m_mis = rd && (tg % 4 != 0);
    if (rd) begin
      if (!m_started) begin
        m_started = 1'b1;
      end else if (m_held) begin
        m_held = 1'b0;
        m_inst = NOP;
      end else if (!m_discard && !ak) begin
        m_discard = 1'b1;
        m_old = m_pc;
      end
      m_pc = tg - (tg % 4);
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held) begin
      if (!st) begin
        m_held = 1'b0;
        m_inst = NOP;
        m_pc = m_pc + 32'd4;
      end
    end else if (m_discard) begin
      if (ak) m_discard = 1'b0;
    end else if (ak) begin
      m_held = 1'b1;
      m_inst = rdt;
      m_ipc = m_pc;
    end
  endtask

  vec_t vt[21];
  int   mem_cnt;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    b_ack = 1'b0; b_rdata = 32'h0; b_stall = 1'b0; b_redirect = 1'b0; b_target = 32'h0;

    vt[0]  = mk(0, 32'h0,   0, 0, 32'h0,         1, 32'h0,   0, NOP,          32'h0,   0);
    vt[1]  = mk(0, 32'h0,   0, 0, 32'h0,         1, 32'h0,   0, NOP,          32'h0,   0);
    vt[2]  = mk(0, 32'h0,   0, 0, 32'h0,         1, 32'h0,   0, NOP,          32'h0,   0);
    vt[3]  = mk(0, 32'h0,   0, 1, 32'h0050_0093, 0, 32'h0,   1, 32'h0050_0093, 32'h0,  0);
    vt[4]  = mk(0, 32'h0,   1, 0, 32'h0,         0, 32'h0,   1, 32'h0050_0093, 32'h0,  0);
    vt[5]  = mk(0, 32'h0,   1, 0, 32'h0,         0, 32'h0,   1, 32'h0050_0093, 32'h0,  0);
    vt[6]  = mk(0, 32'h0,   1, 0, 32'h0,         0, 32'h0,   1, 32'h0050_0093, 32'h0,  0);
    vt[7]  = mk(0, 32'h0,   0, 0, 32'h0,         1, 32'h4,   0, NOP,          32'h0,   0);
    vt[8]  = mk(0, 32'h0,   0, 1, 32'h0010_0113, 0, 32'h0,   1, 32'h0010_0113, 32'h4,  0);
    vt[9]  = mk(1, 32'h102, 0, 0, 32'h0,         1, 32'h100, 0, NOP,          32'h0,   1);
    vt[10] = mk(0, 32'h0,   0, 0, 32'h0,         1, 32'h100, 0, NOP,          32'h0,   0);
    vt[11] = mk(1, 32'h200, 0, 0, 32'h0,         1, 32'h100, 0, NOP,          32'h0,   0);
    vt[12] = mk(0, 32'h0,   0, 0, 32'h0,         1, 32'h100, 0, NOP,          32'h0,   0);
    vt[13] = mk(0, 32'h0,   0, 1, 32'hDEAD_BEEF, 1, 32'h200, 0, NOP,          32'h0,   0);
    vt[14] = mk(1, 32'h300, 0, 1, 32'h0020_8193, 1, 32'h300, 0, NOP,          32'h0,   0);
    vt[15] = mk(0, 32'h0,   0, 1, 32'h1234_5678, 0, 32'h0,   1, 32'h1234_5678, 32'h300, 0);
    vt[16] = mk(0, 32'h0,   1, 1, 32'hCAFE_F00D, 0, 32'h0,   1, 32'h1234_5678, 32'h300, 0);
    vt[17] = mk(0, 32'h0,   0, 0, 32'h0,         1, 32'h304, 0, NOP,          32'h0,   0);
    vt[18] = mk(1, 32'h400, 0, 0, 32'h0,         1, 32'h304, 0, NOP,          32'h0,   0);
    vt[19] = mk(1, 32'h503, 0, 0, 32'h0,         1, 32'h304, 0, NOP,          32'h0,   1);
    vt[20] = mk(0, 32'h0,   0, 1, 32'h0BAD_0BAD, 1, 32'h500, 0, NOP,          32'h0,   0);

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_mis", 32'(misaligned_err), 32'h0);
    chk("rst_addr_wrap", b_addr, 32'hFFFF_FFFC);
    rst = 1'b0;
    chk("idle_req", 32'(imem_req), 32'h0);

    // Directed table: basic fetch, stall, redirects in each state
    for (int i = 0; i < 21; i++) begin
      redirect = vt[i].rd; redirect_target = vt[i].tg; stall = vt[i].st;
      imem_ack = vt[i].ak; imem_rdata = vt[i].rdt;
      step();
      chk($sformatf("t%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("t%0d_valid", i), 32'(inst_valid), 32'(vt[i].e_valid));
      chk($sformatf("t%0d_inst", i), inst, vt[i].e_inst);
      if (vt[i].e_valid) chk($sformatf("t%0d_inst_pc", i), inst_pc, vt[i].e_ipc);
      chk($sformatf("t%0d_mis", i), 32'(misaligned_err), 32'(vt[i].e_mis));
    end
    redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;

    // PC wrap from 0xFFFF_FFFC on the alternate-reset instance
    do_reset();
    step();
    chk("wrap_first_addr", b_addr, 32'hFFFF_FFFC);
    chk("wrap_first_req", 32'(b_req), 32'h1);
    b_ack = 1'b1; b_rdata = 32'h00A0_0093;
    step();
    b_ack = 1'b0;
    chk("wrap_valid", 32'(b_valid), 32'h1);
    chk("wrap_inst_pc", b_inst_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_addr", b_addr, 32'h0000_0000);
    chk("wrap_mis", 32'(b_mis), 32'h0);

    // Reset asserted while draining a request
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    chk("disc_req", 32'(imem_req), 32'h1);
    chk("disc_addr", imem_addr, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", 32'(inst_valid), 32'h0);
    chk("arst_inst", inst, NOP);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBADC_0FFE;
    step();
    imem_ack = 1'b0;
    chk("late_ack_req", 32'(imem_req), 32'h1);
    chk("late_ack_addr", imem_addr, 32'h0);
    chk("late_ack_valid", 32'(inst_valid), 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0030_0193;
    step();
    imem_ack = 1'b0;
    chk("post_rst_inst", inst, 32'h0030_0193);
    chk("post_rst_inst_pc", inst_pc, 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    mem_cnt = 1;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_req", 32'(imem_req), 32'(m_started && !m_held));
      if (m_started && !m_held) chk("rnd_addr", imem_addr, m_discard ? m_old : m_pc);
      chk("rnd_valid", 32'(inst_valid), 32'(m_held));
      chk("rnd_inst", inst, m_inst);
      if (m_held) chk("rnd_inst_pc", inst_pc, m_ipc);
      chk("rnd_mis", 32'(misaligned_err), 32'(m_mis));

      redirect = ($urandom_range(0, 11) == 0);
      redirect_target = $urandom;
      stall = ($urandom_range(0, 2) == 0);
      imem_rdata = $urandom;
      if (imem_req) begin
        if (mem_cnt == 0) begin
          imem_ack = 1'b1;
          mem_cnt = $urandom_range(0, 3);
        end else begin
          imem_ack = 1'b0;
          mem_cnt--;
        end
      end else begin
        imem_ack = ($urandom_range(0, 9) == 0);
      end
      model_step(redirect, redirect_target, stall, imem_ack, imem_rdata);
      step();
    end
    redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
